// File: rtl/cla_pkg.sv
// Shared constants, sizing helper and types for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_DEF_WIDTH = 16;
  localparam int CLA_DEF_GROUP = 4;

  // Number of lookahead groups (and pipeline stages after the input register).
  // Returns 0 for an illegal WIDTH/GROUP pair; the top turns that into an
  // elaboration error.
  function automatic int cla_num_groups(input int width, input int group);
    if (group < 1 || width < group || (width % group) != 0) begin
      return 0;
    end
    return width / group;
  endfunction

  // Group-level lookahead terms: the group generates a carry on its own (gg)
  // or passes the incoming carry straight through (gp).
  typedef struct packed {
    logic gg;
    logic gp;
  } cla_grp_t;

endpackage

// File: rtl/cla_group.sv
// Purely combinational GROUP-bit carry-lookahead block.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_DEF_GROUP
)
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             gg,
  output logic             gp,
  output logic             co
);

  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;
  logic [GROUP:0]   w_c;
  logic             w_acc_g;
  logic             w_acc_p;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every internal carry is built as a flat sum of products of g/p terms and
  // ci (no ripple); the product for the top bit doubles as group G/P.
  always_comb begin
    w_c     = '0;
    w_c[0]  = ci;
    w_acc_g = 1'b0;
    w_acc_p = 1'b1;
    gg      = 1'b0;
    gp      = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      w_acc_g = w_g[i];
      w_acc_p = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc_g = w_acc_g | (w_acc_p & w_g[j]);
        w_acc_p = w_acc_p & w_p[j];
      end
      w_c[i+1] = w_acc_g | (w_acc_p & ci);
      if (i == GROUP - 1) begin
        gg = w_acc_g;
        gp = w_acc_p;
      end
    end
  end

  assign s  = w_p ^ w_c[GROUP-1:0];
  assign co = w_c[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit group is resolved
// per stage, so latency is NG+1 edges and throughput is one op per clock.
//
// Handshake: a transfer happens on an edge where valid & ready are both 1.
// The whole pipeline advances together (adv = ~out_valid | out_ready) and
// in_ready = adv, so a stalled output freezes every stage and nothing is lost
// or duplicated. in_ready is combinational from out_valid/out_ready.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEF_WIDTH,
  parameter int GROUP = CLA_DEF_GROUP
)
(
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = cla_num_groups(WIDTH, GROUP);

  if (NG < 1) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
  end

  // r_a/r_b[k]: operands as seen by the group computed in stage k+1 (skew).
  // r_s[k]:     partial result after stage k+1, lower k+1 groups valid (deskew).
  // r_c[k]:     carry entering group k; r_c[NG] is the final carry-out.
  // r_v[k]:     valid bit of stage k; r_v[NG] is out_valid.
  logic [WIDTH-1:0] r_a [NG];
  logic [WIDTH-1:0] r_b [NG];
  logic [WIDTH-1:0] r_s [NG];
  logic             r_c [NG+1];
  logic             r_v [NG+1];
  logic             r_ovf;
  logic             w_adv;

  assign w_adv    = ~r_v[NG] | out_ready;
  assign in_ready = w_adv;

  // Stage 0: capture operands, folding subtract into inverted y and carry-in 1.
  always_ff @(posedge clk) begin
    if (res) begin
      r_v[0] <= 1'b0;
      r_a[0] <= '0;
      r_b[0] <= '0;
      r_c[0] <= 1'b0;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      r_a[0] <= x;
      r_b[0] <= sub ? ~y : y;
      r_c[0] <= sub ? 1'b1 : cin;
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_stage
    logic [GROUP-1:0] w_s;
    logic             w_gg;
    logic             w_gp;
    logic             w_co;
    cla_grp_t         w_grp;
    logic [WIDTH-1:0] w_sum;

    cla_group #(.GROUP(GROUP)) u_grp (
      .a  (r_a[g][g*GROUP +: GROUP]),
      .b  (r_b[g][g*GROUP +: GROUP]),
      .ci (r_c[g]),
      .s  (w_s),
      .gg (w_gg),
      .gp (w_gp),
      .co (w_co)
    );

    assign w_grp = '{gg: w_gg, gp: w_gp};

    if (g == 0) begin : g_lsb
      // The lowest group starts the result word; higher bits are filled later.
      always_comb begin
        w_sum            = '0;
        w_sum[GROUP-1:0] = w_s;
      end
    end else begin : g_upper
      // Merge this group's sum into the lower groups carried from the last stage.
      always_comb begin
        w_sum                   = r_s[g-1];
        w_sum[g*GROUP +: GROUP] = w_s;
      end
    end

    // Stage g+1 register: partial result, group carry-out and valid bit.
    always_ff @(posedge clk) begin
      if (res) begin
        r_s[g]   <= '0;
        r_c[g+1] <= 1'b0;
        r_v[g+1] <= 1'b0;
      end else if (w_adv) begin
        r_s[g]   <= w_sum;
        r_c[g+1] <= w_grp.gg | (w_grp.gp & r_c[g]);
        r_v[g+1] <= r_v[g];
      end
    end

    if (g < NG - 1) begin : g_skew
      logic w_unused_co;
      assign w_unused_co = w_co;

      // Operands for the groups not yet resolved travel alongside.
      always_ff @(posedge clk) begin
        if (res) begin
          r_a[g+1] <= '0;
          r_b[g+1] <= '0;
        end else if (w_adv) begin
          r_a[g+1] <= r_a[g];
          r_b[g+1] <= r_b[g];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum and operand bits.
      always_ff @(posedge clk) begin
        if (res) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_co ^ (w_s[GROUP-1] ^ r_a[g][WIDTH-1] ^ r_b[g][WIDTH-1]);
        end
      end
    end
  end

  assign out_valid = r_v[NG];
  assign z         = r_s[NG-1];
  assign cout      = r_c[NG];
  assign ovf       = r_ovf;

endmodule
